// File: rtl/snr_pkg.sv
// -----------------------------------------------------------------------------
// snr_pkg
// Shared definitions for the SNR measurement path.
// Contents:
//   - Default widths, reused by window_variance_calc and the SNR-linear stage.
//   - State encoding for the window variance FSM.
// -----------------------------------------------------------------------------
package snr_pkg;

  localparam int PPG_SAMPLE_WIDTH = 14;
  localparam int SNR_VAR_WIDTH    = 29;
  localparam int SNR_LOG2_N       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_MEAN   = 3'd2,
    ST_SQUARE = 3'd3,
    ST_RESULT = 3'd4
  } var_state_e;

endpackage

// File: rtl/window_variance_calc.sv
// -----------------------------------------------------------------------------
// window_variance_calc
// Population variance of a window of N = 2^LOG2_N signed samples, computed as
// E[x^2] - E[x]^2 from a running sum and sum of squares.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   start          in   one-cycle request for a new window (honoured in IDLE)
//   sample_valid   in   sample qualifier (ignored outside ACCUM)
//   sample         in   SAMPLE_WIDTH two's-complement sample
//   busy           out  high in every state except IDLE
//   variance       out  VAR_WIDTH unsigned result, held until overwritten
//   done_variance  out  level; set with a new result, cleared by next start
//
// VAR_WIDTH must be at least 2*SAMPLE_WIDTH.
// -----------------------------------------------------------------------------
module window_variance_calc
  import snr_pkg::*;
#(
  parameter int SAMPLE_WIDTH = PPG_SAMPLE_WIDTH,
  parameter int LOG2_N       = SNR_LOG2_N,
  parameter int VAR_WIDTH    = SNR_VAR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           busy,
  output logic [VAR_WIDTH-1:0]           variance,
  output logic                           done_variance
);

  localparam int SUM_W   = SAMPLE_WIDTH + LOG2_N;
  localparam int SQ_W    = 2 * SAMPLE_WIDTH;
  localparam int SUMSQ_W = SQ_W + LOG2_N;

  // Counter value while the last sample of the window is outstanding.
  localparam logic [LOG2_N-1:0] LAST_COUNT = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  var_state_e                     state_q;
  logic signed [SUM_W-1:0]        sum_q;
  logic        [SUMSQ_W-1:0]      sumsq_q;
  logic        [LOG2_N-1:0]       count_q;
  logic signed [SAMPLE_WIDTH-1:0] mean_q;
  logic        [SQ_W-1:0]         ex2_q;
  logic        [SQ_W-1:0]         msq_q;
  logic        [VAR_WIDTH-1:0]    variance_q;
  logic                           done_q;
  logic                           busy_q;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0]   sample_ext_d;
  logic signed [SQ_W-1:0]    sample_sq_s;
  logic        [SUMSQ_W-1:0] sample_sq_d;
  logic signed [SQ_W-1:0]    mean_sq_s;
  logic        [SQ_W-1:0]    mean_sq_d;
  logic        [SQ_W-1:0]    var_d;

  // NOTE: every signal written here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    sample_ext_d = SUM_W'(sample);
    // A square of a SAMPLE_WIDTH value is at most 2^(2*SAMPLE_WIDTH-2), so
    // the signed product is always non-negative and can be read as unsigned.
    sample_sq_s  = SQ_W'(sample) * SQ_W'(sample);
    sample_sq_d  = {{LOG2_N{1'b0}}, sample_sq_s};
    mean_sq_s    = SQ_W'(mean_q) * SQ_W'(mean_q);
    mean_sq_d    = mean_sq_s;
    // Floor truncation of both terms can make msq exceed ex2 by a little;
    // that is a rounding artefact, so the result clamps at zero.
    var_d        = (ex2_q >= msq_q) ? (ex2_q - msq_q) : '0;
  end

  // ---------------------------------------------------------------------------
  // FSM, accumulators and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      sumsq_q    <= '0;
      count_q    <= '0;
      mean_q     <= '0;
      ex2_q      <= '0;
      msq_q      <= '0;
      variance_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // sample_valid is deliberately not looked at here, even together
          // with start: the window begins on the following cycle.
          if (start) begin
            sum_q   <= '0;
            sumsq_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          if (sample_valid) begin
            sum_q   <= sum_q + sample_ext_d;
            sumsq_q <= sumsq_q + sample_sq_d;
            count_q <= count_q + LOG2_N'(1);
            if (count_q == LAST_COUNT) begin
              state_q <= ST_MEAN;
            end
          end
        end

        ST_MEAN: begin
          // Dropping the low LOG2_N bits of a two's-complement sum is the
          // arithmetic shift, i.e. floor division by N.
          mean_q  <= sum_q[SUM_W-1:LOG2_N];
          ex2_q   <= sumsq_q[SUMSQ_W-1:LOG2_N];
          state_q <= ST_SQUARE;
        end

        ST_SQUARE: begin
          msq_q   <= mean_sq_d;
          state_q <= ST_RESULT;
        end

        ST_RESULT: begin
          variance_q <= VAR_WIDTH'(var_d);
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign variance      = variance_q;
  assign done_variance = done_q;

endmodule

// File: tb/tb_window_variance_calc.sv
// -----------------------------------------------------------------------------
// tb_window_variance_calc
// Directed bench for window_variance_calc with N = 4. A window-level model
// tracks the expected busy/done/variance every cycle; hand-computed literals
// pin the results and the done latency of each window.
// -----------------------------------------------------------------------------
module tb_window_variance_calc;

  localparam int SW = 14;
  localparam int LN = 2;
  localparam int VW = 29;
  localparam int N  = 4;

  typedef int win4_t [4];

  logic                 clk          = 1'b0;
  logic                 reset        = 1'b1;
  logic                 start        = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [SW-1:0] sample       = '0;
  logic                 busy;
  logic                 done_variance;
  logic [VW-1:0]        variance;

  int     n_checks = 0;
  int     n_fail   = 0;
  bit     chk_en   = 1'b0;
  longint last_var = 0;

  window_variance_calc #(
    .SAMPLE_WIDTH(SW),
    .LOG2_N      (LN),
    .VAR_WIDTH   (VW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .variance     (variance),
    .done_variance(done_variance)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Window-level model: collects accepted samples, then the result appears
  // three edges after the window fills.
  // ---------------------------------------------------------------------------
  int     win[$];
  bit     m_busy = 1'b0;
  bit     m_done = 1'b0;
  longint m_var  = 0;
  int     m_lat  = 0;

  function automatic longint ref_variance();
    longint s, ss, mean, ex2, msq;
    s  = 0;
    ss = 0;
    foreach (win[i]) begin
      s  += win[i];
      ss += longint'(win[i]) * win[i];
    end
    mean = s / N;
    if ((s % N) != 0 && s < 0) mean = mean - 1;
    ex2 = ss / N;
    msq = mean * mean;
    return (ex2 >= msq) ? ex2 - msq : 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_var  = 0;
      m_lat  = 0;
      win.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        win.delete();
      end
    end else if (m_lat > 0) begin
      m_lat--;
      if (m_lat == 0) begin
        m_var  = ref_variance();
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (sample_valid) begin
      win.push_back(int'(sample));
      if (win.size() == N) m_lat = 3;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, m_busy);
      check("model_done", done_variance, m_done);
      check("model_variance", variance, m_var);
    end
  end

  // ---------------------------------------------------------------------------
  // One window: start, four samples with optional gaps, then latency and
  // result checks against hand-computed values.
  // ---------------------------------------------------------------------------
  task automatic run_window(input string name, input win4_t s, input int gap_max,
                            input bit valid_with_start, input bit start_mid,
                            input longint exp_v);
    int gap;
    @(negedge clk);
    start        = 1'b1;
    sample_valid = valid_with_start;
    sample       = SW'(1000);
    @(negedge clk);
    start        = 1'b0;
    sample_valid = 1'b0;
    check({name, "/done_cleared"}, done_variance, 0);
    check({name, "/var_held"}, variance, last_var);
    check({name, "/busy"}, busy, 1);
    for (int i = 0; i < N; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) @(negedge clk);
      sample_valid = 1'b1;
      sample       = SW'(s[i]);
      @(negedge clk);
      sample_valid = 1'b0;
      if (start_mid && i == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    check({name, "/done_lat0"}, done_variance, 0);
    @(negedge clk);
    check({name, "/done_lat1"}, done_variance, 0);
    @(negedge clk);
    check({name, "/done_lat2"}, done_variance, 0);
    @(negedge clk);
    check({name, "/done_lat3"}, done_variance, 1);
    check({name, "/busy_low"}, busy, 0);
    check({name, "/variance"}, variance, exp_v);
    last_var = exp_v;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset/busy", busy, 0);
    check("reset/done", done_variance, 0);
    check("reset/variance", variance, 0);
    reset = 1'b0;

    run_window("const100", '{100, 100, 100, 100}, 0, 1'b0, 1'b0, 0);
    run_window("alt1",     '{1, -1, 1, -1},       0, 1'b0, 1'b0, 1);
    run_window("ramp",     '{0, 2, 4, 6},         0, 1'b0, 1'b0, 5);
    run_window("clamp",    '{0, 0, 0, -1},        0, 1'b0, 1'b0, 0);
    run_window("minval",   '{-8192, -8192, -8192, -8192}, 0, 1'b0, 1'b0, 0);
    run_window("gap_ramp", '{0, 2, 4, 6},         5, 1'b0, 1'b0, 5);
    run_window("gap_alt",  '{1, -1, 1, -1},       5, 1'b0, 1'b0, 1);
    run_window("vstart",   '{0, 2, 4, 6},         0, 1'b1, 1'b0, 5);
    run_window("midstart", '{1, -1, 1, -1},       2, 1'b0, 1'b1, 1);
    run_window("ramp2",    '{0, 2, 4, 6},         0, 1'b0, 1'b0, 5);

    // Abort a window half way through with reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    sample_valid = 1'b1;
    sample       = SW'(1);
    @(negedge clk);
    sample = SW'(-1);
    @(negedge clk);
    sample_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort/busy", busy, 0);
    check("abort/done", done_variance, 0);
    check("abort/variance", variance, 0);
    last_var = 0;
    run_window("post_reset", '{1, -1, 1, -1}, 0, 1'b0, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_variance_calc.md
# window_variance_calc

Computes the population variance of a fixed-length window of signed PPG samples, using a streaming sum and sum-of-squares. It sits directly upstream of the SNR-linear stage. One instance runs on the filtered signal and drives `variance`. A second instance runs on the noise residual and drives `noise_variance`. Its level-high `done_variance` serves as (or is ANDed into) that stage's `start_snr`.

## Interface
- `SAMPLE_WIDTH`, default 14: signed sample width.
- `LOG2_N`, default 8: window length is N = 2^LOG2_N samples.
- `VAR_WIDTH`, default 29: output width. Must satisfy 2*SAMPLE_WIDTH <= VAR_WIDTH.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle request to begin a new window. Honoured only in IDLE.
- `sample_valid`  in  1: `sample` is valid this cycle.
- `sample`  in  SAMPLE_WIDTH: two's-complement sample.
- `busy`  out  1: high in every state except IDLE.
- `variance`  out  VAR_WIDTH: result, unsigned, zero-extended.
- `done_variance`  out  1: level. Set when a result is written; cleared by the next accepted `start`.

## Operation
- Reset values: `variance`=0, `done_variance`=0, `busy`=0, state=IDLE, all accumulators and the counter at 0.
- FSM states: IDLE, ACCUM, MEAN, SQUARE, RESULT.
- IDLE:
  - On `start`, clear `sum`, `sumsq`, `count` and `done_variance`, then go to ACCUM.
  - `variance` keeps its old value until overwritten.
  - `sample_valid` is ignored in IDLE, including in the same cycle as `start`.
- ACCUM:
  - On each `sample_valid`: sum += sample; sumsq += sample*sample; count += 1.
  - Cycles without `sample_valid` stall with no change.
  - When the sample accepted is the Nth one (count == N-1), go to MEAN.
- MEAN:
  - mean = sum >>> LOG2_N (arithmetic shift, floor toward -inf).
  - ex2 = sumsq >> LOG2_N (logical shift).
  - Go to SQUARE.
- SQUARE: msq = mean*mean (unsigned). Go to RESULT.
- RESULT:
  - `variance` = (ex2 >= msq) ? ex2 - msq : 0. The clamp absorbs floor-truncation artefacts.
  - Set `done_variance`. Go to IDLE.
- Widths:
  - sum: SAMPLE_WIDTH+LOG2_N, signed.
  - sumsq: 2*SAMPLE_WIDTH+LOG2_N, unsigned.
  - mean: SAMPLE_WIDTH, signed.
  - ex2 and msq: 2*SAMPLE_WIDTH, unsigned.
  - No overflow is possible at these widths, so no saturation logic is required beyond the clamp.
- `start` while `busy` is ignored; the window in progress completes.
- `reset` mid-window aborts it. All state returns to reset values on that edge, and any partial window is discarded.

## Timing
- The edge that accepts the Nth sample moves the FSM to MEAN.
- `done_variance` and the new `variance` become visible after the 3rd rising edge following that edge (MEAN, SQUARE, RESULT).
- Minimum window duration, start to done: 1 + N + 3 cycles.
- `busy` goes high on the edge after `start` is sampled. It goes low on the same edge that sets `done_variance`.
- `done_variance` remains high through IDLE until the next accepted `start`. It falls on the edge that samples that `start`.

## Structure
- Shared package `snr_pkg`:
  - FSM state encoding (IDLE/ACCUM/MEAN/SQUARE/RESULT).
  - Default widths `PPG_SAMPLE_WIDTH`=14, `SNR_VAR_WIDTH`=29, `SNR_LOG2_N`=8, reused by the SNR-linear stage.
- No sub-module. The FSM, accumulators and arithmetic live in one module; the squaring multipliers are inferred.

## Test plan
Directed tests use LOG2_N=2 (N=4):
- Constant window: start, then samples 100,100,100,100 -> `variance`=0, `done_variance`=1 exactly 3 edges after the 4th sample.
- Alternating window: samples 1,-1,1,-1 -> sum 0, ex2 1, `variance`=1. Samples 0,2,4,6 -> mean 3, ex2 14, `variance`=5.
- Clamp: samples 0,0,0,-1 -> mean -1, ex2 0, msq 1 -> `variance`=0. Samples -8192 ×4 -> `variance`=0, with no overflow at sumsq=2^28.
- Handshake:
  - `sample_valid` gaps of 0–5 cycles between samples give identical results.
  - `start` during ACCUM is ignored.
  - `start` in the same cycle as a valid sample does not count that sample.
  - A second `start` after done clears `done_variance` on its edge, while `variance` holds its old value until the new RESULT.
- Reset: assert `reset` after 2 of 4 samples -> all outputs return to 0 and `busy`=0. A fresh window of 1,-1,1,-1 then yields 1.
